// File: rtl/call_stack_if.sv
// Request/strobe bundle between the decoder/PC side and the call stack sequencer.
// master: decoder and PC side; slave: the sequencer.
interface call_stack_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  i_call;
    logic                  i_rtrn;
    logic                  i_irq;
    logic                  o_stack_call;
    logic                  o_stack_rtrn;
    logic                  o_pc_load;
    logic [1:0]            o_pc_sel;
    logic                  o_stall;
    logic                  o_irq_ack;
    logic                  o_in_irq;
    logic [ADDR_WIDTH:0]   o_depth;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_call, i_rtrn, i_irq,
        input  o_stack_call, o_stack_rtrn, o_pc_load, o_pc_sel, o_stall,
        input  o_irq_ack, o_in_irq, o_depth, o_overflow, o_underflow
    );

    modport slave (
        input  i_call, i_rtrn, i_irq,
        output o_stack_call, o_stack_rtrn, o_pc_load, o_pc_sel, o_stall,
        output o_irq_ack, o_in_irq, o_depth, o_overflow, o_underflow
    );
endinterface

// File: rtl/call_stack_controller.sv
// FRANK6000 call/return/interrupt sequencer for the instruction stack.
// Define CALL_STACK_GUARD_EN to block pushes when full and pops when empty.
module call_stack_controller #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IRQ_VECTOR = 8'hF0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    call_stack_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_RTRN_WAIT = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] DEPTH_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] DEPTH_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] SEL_PC_INC = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_STACK  = 2'b10;
    localparam logic [1:0] SEL_VECTOR = 2'b11;

    // The PC mux that consumes IRQ_VECTOR sits outside this block.
    if (IRQ_VECTOR == {DATA_WIDTH{1'b0}}) begin : g_vector_at_zero
    end

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_WIDTH:0] depth_r;
    logic [ADDR_WIDTH:0] entry_depth_r;
    logic                in_irq_r;

    logic in_idle_s;
    logic call_req_s;
    logic rtrn_req_s;
    logic irq_req_s;
    logic push_block_s;
    logic pop_block_s;
    logic do_call_s;
    logic do_rtrn_s;
    logic do_irq_s;

`ifdef CALL_STACK_GUARD_EN
    assign push_block_s = (depth_r == DEPTH_FULL);
    assign pop_block_s  = (depth_r == DEPTH_ZERO);
`else
    assign push_block_s = 1'b0;
    assign pop_block_s  = 1'b0;
`endif

    // Request arbitration in IDLE: call beats rtrn beats irq.
    always_comb begin
        in_idle_s  = (state_r == ST_IDLE) && !i_rst;
        call_req_s = in_idle_s && bus.i_call;
        rtrn_req_s = in_idle_s && !bus.i_call && bus.i_rtrn;
        irq_req_s  = in_idle_s && !bus.i_call && !bus.i_rtrn && bus.i_irq && !in_irq_r;
        do_call_s  = call_req_s && !push_block_s;
        do_rtrn_s  = rtrn_req_s && !pop_block_s;
        do_irq_s   = irq_req_s && !push_block_s;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a return always spends exactly one cycle in RTRN_WAIT.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (do_rtrn_s) begin
                    state_next_s = ST_RTRN_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RTRN_WAIT: state_next_s = ST_IDLE;
            default:      state_next_s = ST_IDLE;
        endcase
    end

    // Strobe and PC-select decode.
    always_comb begin
        bus.o_stack_call = 1'b0;
        bus.o_stack_rtrn = 1'b0;
        bus.o_pc_load    = 1'b0;
        bus.o_pc_sel     = SEL_PC_INC;
        bus.o_stall      = 1'b0;
        bus.o_irq_ack    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (do_call_s) begin
                    bus.o_stack_call = 1'b1;
                    bus.o_pc_load    = 1'b1;
                    bus.o_pc_sel     = SEL_BRANCH;
                end else if (do_rtrn_s) begin
                    bus.o_stack_rtrn = 1'b1;
                    bus.o_stall      = 1'b1;
                end else if (do_irq_s) begin
                    bus.o_stack_call = 1'b1;
                    bus.o_pc_load    = 1'b1;
                    bus.o_pc_sel     = SEL_VECTOR;
                    bus.o_irq_ack    = 1'b1;
                end else begin
                    bus.o_pc_sel     = SEL_PC_INC;
                end
            end
            ST_RTRN_WAIT: begin
                // Stack RAM output is valid now; reset aborts the load.
                if (!i_rst) begin
                    bus.o_pc_load = 1'b1;
                    bus.o_pc_sel  = SEL_STACK;
                end else begin
                    bus.o_pc_load = 1'b0;
                end
            end
            default: begin
                bus.o_pc_load = 1'b0;
            end
        endcase
    end

    // Depth counter and interrupt-handler tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            depth_r       <= DEPTH_ZERO;
            entry_depth_r <= DEPTH_ZERO;
            in_irq_r      <= 1'b0;
        end else begin
            if (do_call_s || do_irq_s) begin
                depth_r <= depth_r + DEPTH_ONE;
            end else if (do_rtrn_s) begin
                depth_r <= depth_r - DEPTH_ONE;
            end else begin
                depth_r <= depth_r;
            end
            if (do_irq_s) begin
                in_irq_r      <= 1'b1;
                entry_depth_r <= depth_r;
            end else if ((state_r == ST_RTRN_WAIT) && (depth_r == entry_depth_r)) begin
                // depth_r already holds the post-pop value here.
                in_irq_r <= 1'b0;
            end else begin
                in_irq_r <= in_irq_r;
            end
        end
    end

    assign bus.o_depth  = depth_r;
    assign bus.o_in_irq = in_irq_r;

`ifdef CALL_STACK_GUARD_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky fault flags; only reset clears them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if ((call_req_s || irq_req_s) && push_block_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (rtrn_req_s && pop_block_s) begin
                underflow_r <= 1'b1;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    assign bus.o_overflow  = overflow_r;
    assign bus.o_underflow = underflow_r;
`else
    assign bus.o_overflow  = 1'b0;
    assign bus.o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack_controller.sv
// Self-checking bench: directed test-plan sequences then random traffic against a behavioural model.
module tb_call_stack_controller;

    localparam int AW  = 4;
    localparam int CAP = 1 << AW;
    localparam int MOD = 2 * CAP;
`ifdef CALL_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic i_clk;
    logic i_rst;

    call_stack_if #(.ADDR_WIDTH(AW)) bus ();

    call_stack_controller #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(8),
        .IRQ_VECTOR(8'hF0)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Model state: architectural view of the stack sequencer.
    int m_depth;
    int m_entry;
    bit m_in_irq;
    bit m_wait;
    bit m_ovf;
    bit m_unf;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_depth  = 0;
        m_entry  = 0;
        m_in_irq = 1'b0;
        m_wait   = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    // One clock cycle: apply inputs, predict, check mid-cycle, advance model on the edge.
    task automatic step(input bit rst, input bit call, input bit rtrn, input bit irq);
        bit e_sc, e_sr, e_ld, e_st, e_ack;
        int e_sel;
        int n_depth, n_entry;
        bit n_in_irq, n_wait, n_ovf, n_unf;
        i_rst      = rst;
        bus.i_call = call;
        bus.i_rtrn = rtrn;
        bus.i_irq  = irq;
        e_sc = 0; e_sr = 0; e_ld = 0; e_st = 0; e_ack = 0; e_sel = 0;
        n_depth = m_depth; n_entry = m_entry; n_in_irq = m_in_irq;
        n_wait = 0; n_ovf = m_ovf; n_unf = m_unf;
        if (rst) begin
            n_depth = 0; n_entry = 0; n_in_irq = 0; n_ovf = 0; n_unf = 0;
        end else if (m_wait) begin
            e_ld = 1; e_sel = 2;
            if (m_in_irq && m_depth == m_entry) n_in_irq = 0;
        end else if (call) begin
            if (GUARD && m_depth == CAP) n_ovf = 1;
            else begin
                e_sc = 1; e_ld = 1; e_sel = 1;
                n_depth = (m_depth + 1) % MOD;
            end
        end else if (rtrn) begin
            if (GUARD && m_depth == 0) n_unf = 1;
            else begin
                e_sr = 1; e_st = 1; n_wait = 1;
                n_depth = (m_depth + MOD - 1) % MOD;
            end
        end else if (irq && !m_in_irq) begin
            if (GUARD && m_depth == CAP) n_ovf = 1;
            else begin
                e_sc = 1; e_ld = 1; e_sel = 3; e_ack = 1;
                n_depth = (m_depth + 1) % MOD;
                n_in_irq = 1; n_entry = m_depth;
            end
        end
        @(negedge i_clk);
        check_val("stack_call", bus.o_stack_call, e_sc);
        check_val("stack_rtrn", bus.o_stack_rtrn, e_sr);
        check_val("pc_load", bus.o_pc_load, e_ld);
        check_val("pc_sel", bus.o_pc_sel, e_sel);
        check_val("stall", bus.o_stall, e_st);
        check_val("irq_ack", bus.o_irq_ack, e_ack);
        check_val("depth", bus.o_depth, m_depth);
        check_val("in_irq", bus.o_in_irq, m_in_irq);
        check_val("overflow", bus.o_overflow, m_ovf);
        check_val("underflow", bus.o_underflow, m_unf);
        @(posedge i_clk);
        m_depth = n_depth; m_entry = n_entry; m_in_irq = n_in_irq;
        m_wait = n_wait; m_ovf = n_ovf; m_unf = n_unf;
        #1;
    endtask

    initial begin
        i_rst      = 1'b1;
        bus.i_call = 1'b0;
        bus.i_rtrn = 1'b0;
        bus.i_irq  = 1'b0;
        @(posedge i_clk);
        #1;
        model_reset();
        step(1, 1, 1, 1);   // reset dominates active requests
        step(0, 0, 0, 0);

        // single call then return
        step(0, 1, 0, 0);
        check_val("call_depth1", bus.o_depth, 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_val("rtrn_depth0", bus.o_depth, 0);

        // fill to capacity and one beyond
        for (int i = 0; i < CAP + 1; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
`ifdef CALL_STACK_GUARD_EN
        check_val("full_hold", bus.o_depth, CAP);
        check_val("ovf_sticky", bus.o_overflow, 1);
`else
        check_val("full_wrapless", bus.o_depth, CAP + 1);
`endif

        // return while empty
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
`ifdef CALL_STACK_GUARD_EN
        check_val("unf_sticky", bus.o_underflow, 1);
        check_val("unf_depth", bus.o_depth, 0);
`else
        check_val("wrap31", bus.o_depth, MOD - 1);
`endif

        // interrupt at depth 2, nested call, two returns
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        check_val("irq_in", bus.o_in_irq, 1);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check_val("irq_still", bus.o_in_irq, 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check_val("irq_clear", bus.o_in_irq, 0);
        check_val("irq_clear_depth", bus.o_depth, 2);

        // simultaneous call and irq
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        check_val("irq_after_call", bus.o_in_irq, 1);

        // reset in RTRN_WAIT
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check_val("rst_abort_depth", bus.o_depth, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(3) == 0,
                 $urandom_range(3) == 0,
                 $urandom_range(2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
